// File: rtl/bean_pkg.sv
// Shared BEAN core definitions used by the fetch/decode path.
//   XPR_LEN               : instruction and PC width in bits
//   DECODER_CHANNEL_DEPTH : number of decoder channel slots
//   fetch_entry_t         : one buffered fetch result {pc, inst}
//   thermo_empty()        : per-slot empty vector from an occupancy count
package bean_pkg;

  localparam int unsigned XPR_LEN               = 32;
  localparam int unsigned DECODER_CHANNEL_DEPTH = 4;
  localparam int unsigned CHANNEL_CNT_W         = $clog2(DECODER_CHANNEL_DEPTH) + 1;

  typedef struct packed {
    logic [XPR_LEN-1:0] pc;
    logic [XPR_LEN-1:0] inst;
  } fetch_entry_t;

  // Bit i is set when slot i is at or beyond the occupancy count (thermometer code).
  function automatic logic [DECODER_CHANNEL_DEPTH-1:0] thermo_empty(
    input logic [CHANNEL_CNT_W-1:0] count
  );
    logic [DECODER_CHANNEL_DEPTH-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < DECODER_CHANNEL_DEPTH; i++) begin
      res[i] = (CHANNEL_CNT_W'(i) >= count);
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Storage array for the instruction queue: DEPTH x WIDTH registers with one
// synchronous write port and one asynchronous read port. No reset; contents
// are only meaningful where the owning queue says an entry is occupied.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from the array)
module inst_queue_mem #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. Buffers {inst, pc} pairs in a
// DEPTH-entry circular FIFO and presents them in program order. All outputs
// are driven from registers only; drop flushes every entry on the next edge.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_inst/in_pc: fetch push request and payload
//   in_ready              : space available (no pass-through when full)
//   out_valid/inst/pc     : head entry (payload forced to 0 when empty)
//   out_ready             : decoder consumes the head
//   slot_empty            : bit i set when logical slot head+i is unoccupied
//   count                 : number of occupied entries
//   drop                  : flush (redirect); beats push and pop
module inst_queue
  import bean_pkg::*;
#(
  parameter int unsigned XPR_LEN = bean_pkg::XPR_LEN,
  parameter int unsigned DEPTH   = bean_pkg::DECODER_CHANNEL_DEPTH,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [XPR_LEN-1:0] in_inst,
  input  logic [XPR_LEN-1:0] in_pc,
  output logic               in_ready,
  output logic               out_valid,
  output logic [XPR_LEN-1:0] out_inst,
  output logic [XPR_LEN-1:0] out_pc,
  input  logic               out_ready,
  output logic [DEPTH-1:0]   slot_empty,
  output logic [CW-1:0]      count,
  input  logic               drop
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [2*XPR_LEN-1:0] wdata, rdata;

  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != '0);

  // A push coincident with drop must not land in storage or move tail.
  assign push = in_valid && in_ready && !drop;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drop) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry layout: pc in the upper half, inst in the lower half.
  assign wdata = {in_pc, in_inst};

  inst_queue_mem #(
    .WIDTH (2 * XPR_LEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (wdata),
    .raddr (head_q),
    .rdata (rdata)
  );

  assign out_inst = out_valid ? rdata[XPR_LEN-1:0]         : '0;
  assign out_pc   = out_valid ? rdata[2*XPR_LEN-1:XPR_LEN] : '0;
  assign count    = count_q;

  // Reuse the decoder's helper when the queue matches the channel depth.
  if (DEPTH == DECODER_CHANNEL_DEPTH) begin : g_thermo_pkg
    assign slot_empty = thermo_empty(count_q);
  end else begin : g_thermo_local
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign slot_empty[i] = (CW'(i) >= count_q);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  localparam int unsigned XL    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [XL-1:0]    in_inst;
  logic [XL-1:0]    in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [XL-1:0]    out_inst;
  logic [XL-1:0]    out_pc;
  logic             out_ready;
  logic [DEPTH-1:0] slot_empty;
  logic [CW-1:0]    count;
  logic             drop;

  inst_queue #(
    .XPR_LEN (XL),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .slot_empty (slot_empty),
    .count      (count),
    .drop       (drop)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  // Clock starts late so the reset values can be observed with no edge at all.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered list of {inst, pc} occupying the queue.
  typedef struct packed {
    logic [XL-1:0] inst;
    logic [XL-1:0] pc;
  } ent_t;
  ent_t mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      bit can_push, do_pop;
      can_push = in_valid && (mq.size() != DEPTH);
      do_pop   = out_ready && (mq.size() != 0);
      if (drop) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (can_push) mq.push_back('{inst: in_inst, pc: in_pc});
      end
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      logic [DEPTH-1:0] exp_se;
      logic [XL-1:0]    exp_inst, exp_pc;
      for (int i = 0; i < DEPTH; i++) exp_se[i] = (i >= mq.size());
      exp_inst = (mq.size() != 0) ? mq[0].inst : '0;
      exp_pc   = (mq.size() != 0) ? mq[0].pc   : '0;
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      check("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("m_slot_empty", 64'(slot_empty), 64'(exp_se));
      check("m_out_inst", 64'(out_inst), 64'(exp_inst));
      check("m_out_pc", 64'(out_pc), 64'(exp_pc));
    end
  end

  task automatic drive(input logic v, input logic [XL-1:0] inst, input logic [XL-1:0] pc,
                       input logic ordy, input logic drp);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    drop      = drp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [XL-1:0] fill_inst [4];

  initial begin
    fill_inst[0] = 32'h0000_0013;
    fill_inst[1] = 32'h0010_0093;
    fill_inst[2] = 32'h0020_0113;
    fill_inst[3] = 32'h0030_0193;

    drive(0, '0, '0, 0, 0);
    rst = 1'b1;
    #5;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_slot_empty", 64'(slot_empty), 64'hf);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);

    step();
    rst = 1'b0;
    model_on = 1'b1;

    // Fill with no consumer.
    for (int k = 0; k < 4; k++) begin
      drive(1, fill_inst[k], XL'(4 * k), 0, 0);
      step();
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    check("full_slot_empty", 64'(slot_empty), 64'h0);

    // Fifth push while full must be ignored.
    drive(1, 32'hdead_beef, 32'h10, 0, 0);
    step();
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_head", 64'(out_inst), 64'h13);

    // Drain in order.
    drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      check("drain_inst", 64'(out_inst), 64'(fill_inst[k]));
      check("drain_pc", 64'(out_pc), 64'(4 * k));
      step();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);

    // Wrap-around with simultaneous push/pop at count 2.
    drive(1, 32'h0000_1000, 32'h20, 0, 0);
    step();
    drive(1, 32'h0000_1001, 32'h24, 0, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      check("wrap_count", 64'(count), 64'd2);
      check("wrap_pc", 64'(out_pc), 64'(32'h20 + 4 * k));
      drive(1, 32'h0000_1002 + k, XL'(32'h28 + 4 * k), 1, 0);
      step();
    end
    check("wrap_end_count", 64'(count), 64'd2);
    check("wrap_end_pc", 64'(out_pc), 64'h48);

    // Top up to full, then push+pop at full: pop only.
    drive(1, 32'h0000_2000, 32'h50, 0, 0);
    step();
    drive(1, 32'h0000_2001, 32'h54, 0, 0);
    step();
    check("top_count", 64'(count), 64'd4);
    drive(1, 32'h0bad_0bad, 32'h999, 1, 0);
    step();
    check("fullpp_count", 64'(count), 64'd3);
    check("fullpp_head", 64'(out_pc), 64'h4c);

    // Drop beats simultaneous push and pop.
    drive(1, 32'h0000_1234, 32'h200, 1, 1);
    step();
    check("drop_count", 64'(count), 64'd0);
    check("drop_valid", 64'(out_valid), 64'd0);
    check("drop_ready", 64'(in_ready), 64'd1);

    drive(1, 32'h0040_0213, 32'h100, 0, 0);
    step();
    check("post_drop_pc", 64'(out_pc), 64'h100);
    check("post_drop_inst", 64'(out_inst), 64'h0040_0213);

    // Backpressure: head stays put while the queue fills.
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h0000_0500 + k, XL'(32'h104 + 4 * k), 0, 0);
      step();
      check("bp_pc", 64'(out_pc), 64'h100);
      check("bp_inst", 64'(out_inst), 64'h0040_0213);
      check("bp_count", 64'((k + 2 > 4) ? 4 : k + 2), 64'(count) ^ 64'h0 ^ 64'h0 + 64'h0);
    end

    // Asynchronous reset mid-operation, away from a clock edge.
    drive(0, '0, '0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_slot_empty", 64'(slot_empty), 64'hf);
    step();
    rst = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete, expected finish before 20000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
